// File: rtl/eth_hex_dump_pkg.sv
// Shared types and ASCII helpers for the Ethernet hex-dump renderer.
package eth_hex_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_HI, S_LO, S_SEP, S_CR, S_LF
  } state_t;

  typedef enum logic {PH_ISSUE, PH_WAIT} phase_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'h0, n};
    else           return ASCII_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/eth_hex_dump_if.sv
// FIFO read side and UART transmitter handshake of the hex-dump block.
interface eth_hex_dump_if;
  logic [7:0] i_Fifo_Data;
  logic       i_Fifo_Empty;
  logic       o_Fifo_Read;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       i_TX_Active;
  logic       i_TX_Done;
  logic       o_Busy;

  modport master (
    input  i_Fifo_Data, i_Fifo_Empty, i_TX_Active, i_TX_Done,
    output o_Fifo_Read, o_TX_DV, o_TX_Byte, o_Busy
  );

  modport slave (
    output i_Fifo_Data, i_Fifo_Empty, i_TX_Active, i_TX_Done,
    input  o_Fifo_Read, o_TX_DV, o_TX_Byte, o_Busy
  );
endinterface

// File: rtl/eth_hex_dump_uart_char_issue.sv
// One-character ISSUE/WAIT handshake: strobe the UART once when it is idle,
// then wait for its done pulse.
module uart_char_issue
  import eth_hex_dump_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] chr,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  output logic       char_done
);

  phase_t phase, phase_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= PH_ISSUE;
    else     phase <= phase_nx;
  end

  // A done pulse during ISSUE belongs to a character sent before a reset.
  always_comb begin
    phase_nx  = phase;
    tx_dv     = 1'b0;
    char_done = 1'b0;
    case (phase)
      PH_ISSUE: if (req && !tx_active) begin
        tx_dv    = 1'b1;
        phase_nx = PH_WAIT;
      end
      PH_WAIT: if (tx_done) begin
        char_done = 1'b1;
        phase_nx  = PH_ISSUE;
      end
      default: phase_nx = PH_ISSUE;
    endcase
  end

  assign tx_byte = chr;

endmodule

// File: rtl/eth_hex_dump.sv
// Pops raw bytes from the CDC FIFO and prints them as "HH " with CR LF line
// breaks after BYTES_PER_LINE bytes or after an idle gap.
module eth_hex_dump
  import eth_hex_dump_pkg::*;
#(
  parameter int         BYTES_PER_LINE = 16,
  parameter int         IDLE_TIMEOUT   = 4800,
  parameter logic [7:0] SEP_CHAR       = 8'h20
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  eth_hex_dump_if.master bus
);

  localparam logic [7:0]  LINE_LAST = 8'(BYTES_PER_LINE - 1);
  localparam logic [19:0] IDLE_LAST = 20'(IDLE_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [7:0]  line_cnt, line_nx;
  logic [19:0] idle_cnt, idle_nx;
  logic [7:0]  byte_q, byte_nx;
  logic        char_req, char_done;
  logic [7:0]  char_val;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= S_IDLE;
      line_cnt <= 8'h00;
      idle_cnt <= 20'h0;
      byte_q   <= 8'h00;
    end else begin
      state    <= state_nx;
      line_cnt <= line_nx;
      idle_cnt <= idle_nx;
      byte_q   <= byte_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    line_nx         = line_cnt;
    idle_nx         = idle_cnt;
    byte_nx         = byte_q;
    char_req        = 1'b0;
    char_val        = 8'h00;
    bus.o_Fifo_Read = 1'b0;
    bus.o_Busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // New data always wins over closing the line.
        if (!bus.i_Fifo_Empty)        state_nx = S_POP;
        else if (line_cnt == 8'h00)   idle_nx  = 20'h0;
        else if (idle_cnt >= IDLE_LAST) state_nx = S_CR;
        else if (idle_cnt != '1)      idle_nx  = idle_cnt + 20'h1;
      end
      S_POP: begin
        byte_nx         = bus.i_Fifo_Data;
        bus.o_Fifo_Read = 1'b1;
        idle_nx         = 20'h0;
        state_nx        = S_HI;
      end
      S_HI: begin
        char_req = 1'b1;
        char_val = nib2hex(byte_q[7:4]);
        if (char_done) state_nx = S_LO;
      end
      S_LO: begin
        char_req = 1'b1;
        char_val = nib2hex(byte_q[3:0]);
        if (char_done) begin
          if (line_cnt == LINE_LAST) state_nx = S_CR;
          else begin
            line_nx  = line_cnt + 8'h01;
            state_nx = S_SEP;
          end
        end
      end
      S_SEP: begin
        char_req = 1'b1;
        char_val = SEP_CHAR;
        if (char_done) state_nx = S_IDLE;
      end
      S_CR: begin
        char_req = 1'b1;
        char_val = ASCII_CR;
        if (char_done) state_nx = S_LF;
      end
      S_LF: begin
        char_req = 1'b1;
        char_val = ASCII_LF;
        if (char_done) begin
          line_nx  = 8'h00;
          idle_nx  = 20'h0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  uart_char_issue u_issue (
    .clk       (i_Clock),
    .rst       (i_Reset),
    .req       (char_req),
    .chr       (char_val),
    .tx_active (bus.i_TX_Active),
    .tx_done   (bus.i_TX_Done),
    .tx_dv     (bus.o_TX_DV),
    .tx_byte   (bus.o_TX_Byte),
    .char_done (char_done)
  );

endmodule

// File: tb/tb_eth_hex_dump.sv
// Scoreboard bench: a text-level model predicts the character stream, a
// negedge monitor compares every UART strobe against it.
module tb_eth_hex_dump;
  localparam int BPL = 4;
  localparam int TMO = 50;

  typedef struct { logic [7:0] ch; bit tmo; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_hex_dump_if ifc();

  eth_hex_dump #(.BYTES_PER_LINE(BPL), .IDLE_TIMEOUT(TMO), .SEP_CHAR(8'h20)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (ifc)
  );

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  string      HEXS = "0123456789ABCDEF";
  int checks = 0, fails = 0;
  int cyc = 0, line = 0, dv_count = 0, last_done = 0, pops = 0, fed = 0;
  bit pend_pop = 0, start_pend = 0, hold_valid = 0;
  logic uact = 1'b0, force_act = 1'b0;
  int ucnt = 0;
  logic [7:0] ucap = 8'h00;

  assign ifc.i_TX_Active = uact | force_act;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] c, input bit t);
    exp_t e;
    e.ch = c; e.tmo = t;
    exp_q.push_back(e);
  endtask

  // Text model: "HH" per byte, space between bytes, CR LF on a full line.
  task automatic feed(input logic [7:0] b);
    fifo_q.push_back(b);
    fed++;
    push_exp(HEXS[int'(b[7:4])], 1'b0);
    push_exp(HEXS[int'(b[3:0])], 1'b0);
    line++;
    if (line == BPL) begin
      push_exp(8'h0D, 1'b0); push_exp(8'h0A, 1'b0); line = 0;
    end else push_exp(8'h20, 1'b0);
  endtask

  // A long gap closes an open line.
  task automatic end_burst();
    if (line != 0) begin
      push_exp(8'h0D, 1'b1); push_exp(8'h0A, 1'b0); line = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 6000) begin
      @(posedge clk); n++;
    end
    chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    repeat (120) @(posedge clk);
    #2;
    chk(ifc.o_Busy == 1'b0, "idle_busy", ifc.o_Busy, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(ifc.o_TX_DV == 1'b0,      {tag, "_tx_dv"},   ifc.o_TX_DV, 0);
    chk(ifc.o_Fifo_Read == 1'b0,  {tag, "_read"},    ifc.o_Fifo_Read, 0);
    chk(ifc.o_Busy == 1'b0,       {tag, "_busy"},    ifc.o_Busy, 0);
    chk(ifc.o_TX_Byte == 8'h00,   {tag, "_tx_byte"}, ifc.o_TX_Byte, 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // UART: active from the cycle after the strobe for 20 cycles, then done.
  always @(posedge clk) begin
    #1;
    ifc.i_TX_Done = 1'b0;
    if (start_pend) begin
      start_pend = 0; ucnt = 20; uact = 1'b1;
    end else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) begin uact = 1'b0; ifc.i_TX_Done = 1'b1; end
    end
  end

  // FIFO model and monitor; a pop takes effect after the DUT latched the data.
  always @(negedge clk) begin : mon
    exp_t e;
    if (pend_pop) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pend_pop = 0;
    end
    if (ifc.o_Fifo_Read) begin
      chk(fifo_q.size() > 0 && !ifc.i_Fifo_Empty, "pop_nonempty", ifc.i_Fifo_Empty, 0);
      pend_pop = 1; pops++;
    end
    if (ifc.o_TX_DV) begin
      dv_count++;
      chk(ifc.i_TX_Active == 1'b0, "dv_while_active", ifc.i_TX_Active, 0);
      chk(exp_q.size() != 0, "unexpected_char", ifc.o_TX_Byte, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(ifc.o_TX_Byte == e.ch, "tx_byte", ifc.o_TX_Byte, e.ch);
        if (e.tmo)
          chk(cyc - last_done >= TMO - 1 && cyc - last_done <= TMO + 2,
              "timeout_gap", cyc - last_done, TMO);
      end
      ucap = ifc.o_TX_Byte; start_pend = 1; hold_valid = 1;
    end
    if (ifc.i_TX_Done) begin
      if (hold_valid) chk(ifc.o_TX_Byte == ucap, "tx_byte_hold", ifc.o_TX_Byte, ucap);
      hold_valid = 0;
      last_done = cyc;
    end
    ifc.i_Fifo_Empty = (fifo_q.size() == 0);
    ifc.i_Fifo_Data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int p0, d0, w;
    ifc.i_Fifo_Empty = 1'b1;
    ifc.i_Fifo_Data  = 8'h00;
    ifc.i_TX_Done    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Single byte, line closed by the idle timeout.
    p0 = pops;
    feed(8'hA5); end_burst(); drain();
    chk(pops == p0 + 1, "single_pop_count", pops - p0, 1);

    // Full line.
    for (int i = 0; i < 4; i++) feed(8'(i));
    end_burst(); drain();

    feed(8'h3C); end_burst(); drain();

    // UART held busy: no strobe, then a strobe right after release.
    @(posedge clk); #1 force_act = 1'b1;
    d0 = dv_count;
    feed(8'h5B);
    repeat (100) @(posedge clk);
    chk(dv_count == d0, "stall_no_dv", dv_count - d0, 0);
    #1 force_act = 1'b0;
    w = 0;
    while (dv_count == d0 && w < 4) begin @(posedge clk); w++; end
    chk(dv_count == d0 + 1 && w <= 2, "stall_release_latency", w, 1);
    end_burst(); drain();

    // Reset during the LO character of the second byte of an open line.
    d0 = dv_count;
    feed(8'h11); feed(8'h7E);
    w = 0;
    while (dv_count < d0 + 5 && w < 2000) begin @(posedge clk); w++; end
    chk(dv_count == d0 + 5, "reach_lo", dv_count - d0, 5);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk_outputs_zero("async_reset");
    exp_q.delete(); line = 0; hold_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    feed(8'h5A); feed(8'h01); feed(8'h02); feed(8'h03);
    end_burst(); drain();

    // Back-to-back bytes.
    p0 = pops;
    feed(8'hFF); feed(8'h0A); end_burst(); drain();
    chk(pops == p0 + 2, "b2b_pop_count", pops - p0, 2);

    // Random bursts.
    for (int b = 0; b < 8; b++) begin
      int n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) feed(8'($urandom_range(0, 255)));
      end_burst(); drain();
    end
    chk(pops == fed, "total_pops", pops, fed);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
